// File: rtl/tenary_conv_sched.sv
// Layer scheduler for the ternary convolution datapath: walks output windows
// (col innermost, then channel group, then row), then flushes the pipe.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one fire per valid window
// DRAIN | issuing DRAIN_CYCLES flush fires
// DONE  | one-cycle layer_done pulse
module tenary_conv_sched #(
  parameter int INPUT_SIZE    = 16,
  parameter int TI            = 3,
  parameter int INPUT_CHANNEL = 3,
  parameter int ADDR_BITS     = 4,
  parameter int DRAIN_CYCLES  = TI + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 src_valid,
  input  logic                 dp_done,
  input  logic                 out_ready,
  output logic                 fire,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 out_valid,
  output logic [ADDR_BITS-1:0] row,
  output logic [ADDR_BITS-1:0] col,
  output logic [7:0]           ch_grp,
  output logic [7:0]           wt_addr,
  output logic                 ovf_err
);

  localparam int ITER = INPUT_CHANNEL / TI;
  localparam int DW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_POS   = ADDR_BITS'(INPUT_SIZE - 1);
  localparam logic [7:0]           LAST_GRP   = 8'(ITER - 1);
  localparam logic [DW-1:0]        DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  drain_cnt;
  logic           stall;
  logic           col_wrap;
  logic           grp_wrap;
  logic           last_win;
  logic [7:0]     grp_nxt;

  assign stall    = out_valid & ~out_ready;
  assign col_wrap = (col == LAST_POS);
  assign grp_wrap = col_wrap && (ch_grp == LAST_GRP);
  assign last_win = grp_wrap && (row == LAST_POS);
  assign grp_nxt  = (ch_grp == LAST_GRP) ? 8'd0 : ch_grp + 8'd1;

  always_comb begin
    state_nxt  = state;
    fire       = 1'b0;
    busy       = 1'b0;
    layer_done = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        fire = src_valid & ~stall;
        if (fire && last_win) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        fire = ~stall;
        if (fire && drain_cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        layer_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Outputs are forced quiet while reset is held, not just after the edge.
    if (rst) begin
      fire       = 1'b0;
      busy       = 1'b0;
      layer_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      ch_grp    <= '0;
      wt_addr   <= '0;
      drain_cnt <= '0;
      out_valid <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_RUN && fire) begin
        if (last_win) begin
          row       <= '0;
          col       <= '0;
          ch_grp    <= '0;
          wt_addr   <= '0;
          drain_cnt <= DRAIN_LOAD;
        end else begin
          col <= col_wrap ? '0 : col + ADDR_BITS'(1);
          if (col_wrap) begin
            ch_grp  <= grp_nxt;
            wt_addr <= grp_nxt;
          end
          if (grp_wrap) row <= row + ADDR_BITS'(1);
        end
      end
      // Down-counter of drain fires; stalled cycles leave it untouched.
      if (state == S_DRAIN && fire && drain_cnt != '0)
        drain_cnt <= drain_cnt - DW'(1);
      if (dp_done)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
      if (dp_done && stall)
        ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tenary_conv_sched.sv
// Self-checking bench for tenary_conv_sched: directed layers plus random
// traffic, checked every cycle against a fire-count based reference model.
module tb_tenary_conv_sched;

  localparam int IS      = 4;
  localparam int TI_P    = 3;
  localparam int IC      = 6;
  localparam int AB      = 4;
  localparam int DC      = TI_P + 2;
  localparam int ITER    = IC / TI_P;
  localparam int N_RUN   = IS * IS * ITER;
  localparam int N_DRAIN = DC;

  logic clk = 1'b0;
  logic rst, start, src_valid, dp_done, out_ready;
  logic fire, busy, layer_done, out_valid, ovf_err;
  logic [AB-1:0] row, col;
  logic [7:0] ch_grp, wt_addr;

  always #5 clk = ~clk;

  tenary_conv_sched #(
    .INPUT_SIZE(IS), .TI(TI_P), .INPUT_CHANNEL(IC),
    .ADDR_BITS(AB), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .src_valid(src_valid),
    .dp_done(dp_done), .out_ready(out_ready), .fire(fire), .busy(busy),
    .layer_done(layer_done), .out_valid(out_valid), .row(row), .col(col),
    .ch_grp(ch_grp), .wt_addr(wt_addr), .ovf_err(ovf_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_row [N_RUN];
  int exp_col [N_RUN];
  int exp_grp [N_RUN];
  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done
  int m_phase = 0;
  int m_fires = 0;
  bit m_ov = 1'b0;
  bit m_ovf = 1'b0;
  int dut_fires, done_pulses, start_cyc, dut_done_cyc, m_done_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit sv, input bit ordy, input bit dpd);
    logic e_fire;
    int e_row, e_col, e_grp;
    @(negedge clk);
    rst = r; start = st; src_valid = sv; out_ready = ordy; dp_done = dpd;
    #1;
    e_fire = 1'b0;
    if (!r) begin
      if (m_phase == 1) e_fire = sv & ~(m_ov & ~ordy);
      else if (m_phase == 2) e_fire = ~(m_ov & ~ordy);
    end
    if (m_phase == 1) begin
      e_row = exp_row[m_fires]; e_col = exp_col[m_fires]; e_grp = exp_grp[m_fires];
    end else begin
      e_row = 0; e_col = 0; e_grp = 0;
    end
    chk("fire", fire, e_fire);
    chk("busy", busy, !r && m_phase != 0);
    chk("layer_done", layer_done, !r && m_phase == 3);
    chk("out_valid", out_valid, m_ov);
    chk("ovf_err", ovf_err, m_ovf);
    chk("row", row, e_row);
    chk("col", col, e_col);
    chk("ch_grp", ch_grp, e_grp);
    chk("wt_addr", wt_addr, e_grp);
    if (fire === 1'b1) dut_fires++;
    if (layer_done === 1'b1) begin dut_done_cyc = cyc; done_pulses++; end
    if (!r && m_phase == 0 && st) start_cyc = cyc;
    if (!r && m_phase == 3) m_done_cyc = cyc;
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_fires = 0; m_ov = 1'b0; m_ovf = 1'b0;
    end else begin
      if (dpd && m_ov && !ordy) m_ovf = 1'b1;
      if (dpd) m_ov = 1'b1;
      else if (ordy) m_ov = 1'b0;
      case (m_phase)
        0: if (st) begin m_phase = 1; m_fires = 0; end
        1: if (e_fire) begin m_fires++; if (m_fires == N_RUN) m_phase = 2; end
        2: if (e_fire) begin m_fires++; if (m_fires == N_RUN + N_DRAIN) m_phase = 3; end
        default: m_phase = 0;
      endcase
    end
    cyc++;
  endtask

  task automatic clear_stats();
    dut_fires = 0; done_pulses = 0; dut_done_cyc = -1; m_done_cyc = -1; start_cyc = 0;
  endtask

  initial begin
    int idx;
    bit sv, ordy, dpd, st;
    idx = 0;
    for (int r = 0; r < IS; r++)
      for (int g = 0; g < ITER; g++)
        for (int c = 0; c < IS; c++) begin
          exp_row[idx] = r; exp_col[idx] = c; exp_grp[idx] = g; idx++;
        end
    clear_stats();

    rst = 1'b1; start = 1'b0; src_valid = 1'b0; dp_done = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 1, 0);

    // Nominal layer
    clear_stats();
    step(0, 1, 1, 1, 0);
    for (int k = 0; k < 200 && done_pulses == 0; k++) step(0, 0, 1, 1, 0);
    chk("nom_fires", dut_fires, N_RUN + N_DRAIN);
    chk("nom_done_pulses", done_pulses, 1);
    chk("nom_latency", dut_done_cyc - start_cyc + 1, 1 + N_RUN + N_DRAIN + 1);
    chk("nom_ovf", ovf_err, 0);
    repeat (3) step(0, 0, 1, 1, 0);

    // Source gaps every other cycle
    clear_stats();
    step(0, 1, 0, 1, 0);
    for (int k = 0; k < 400 && done_pulses == 0; k++) step(0, 0, k % 2 == 1, 1, 0);
    chk("gap_fires", dut_fires, N_RUN + N_DRAIN);
    chk("gap_done_pulses", done_pulses, 1);
    chk("gap_latency", dut_done_cyc - start_cyc + 1, m_done_cyc - start_cyc + 1);
    step(0, 0, 0, 1, 0);

    // Backpressure and overrun
    clear_stats();
    step(0, 1, 1, 1, 0);
    repeat (5) step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    repeat (3) step(0, 0, 1, 0, 0);
    chk("bp_stalled_fires", dut_fires, 6);
    step(0, 0, 1, 0, 1);
    repeat (2) step(0, 0, 1, 0, 0);
    chk("bp_ovf_set", ovf_err, 1);
    for (int k = 0; k < 200 && done_pulses == 0; k++) step(0, 0, 1, 1, 0);
    chk("bp_fires", dut_fires, N_RUN + N_DRAIN);
    chk("bp_done_pulses", done_pulses, 1);
    step(0, 0, 0, 1, 0);
    chk("bp_ovf_sticky", ovf_err, 1);

    // Reset mid-layer, start while busy ignored, then restart
    step(1, 0, 0, 1, 0);
    clear_stats();
    step(0, 1, 1, 1, 0);
    for (int k = 0; k < 100 && m_fires < 10; k++) step(0, m_fires == 4, 1, 1, 0);
    chk("rr_fires_before_rst", dut_fires, 10);
    step(1, 0, 1, 1, 0);
    repeat (5) step(0, 0, 1, 1, 0);
    chk("rr_no_done", done_pulses, 0);
    chk("rr_idle", busy, 0);
    clear_stats();
    step(0, 1, 1, 1, 0);
    for (int k = 0; k < 200 && done_pulses == 0; k++) step(0, 0, 1, 1, 0);
    chk("rr_fires", dut_fires, N_RUN + N_DRAIN);
    chk("rr_done_pulses", done_pulses, 1);
    chk("rr_latency", dut_done_cyc - start_cyc + 1, 1 + N_RUN + N_DRAIN + 1);

    // Random traffic
    step(1, 0, 0, 1, 0);
    for (int l = 0; l < 3; l++) begin
      clear_stats();
      step(0, 1, 1, 1, 0);
      for (int k = 0; k < 800 && done_pulses == 0; k++) begin
        sv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        dpd  = ($urandom_range(0, 4) == 0);
        st   = ($urandom_range(0, 7) == 0);
        step(0, st, sv, ordy, dpd);
      end
      chk("rnd_fires", dut_fires, N_RUN + N_DRAIN);
      chk("rnd_done_pulses", done_pulses, 1);
      chk("rnd_latency", dut_done_cyc - start_cyc + 1, m_done_cyc - start_cyc + 1);
      step(0, 0, 0, 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tenary_conv_sched.md
TENARY_CONV_SCHED -- requirements
Module: tenary_conv_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- INPUT_SIZE, 16, feature-map rows and columns
- TI, 3, input channels per group
- INPUT_CHANNEL, 3, total input channels; ITER = INPUT_CHANNEL/TI
- ADDR_BITS, 4, row/column counter width
- DRAIN_CYCLES, TI+2, fire pulses issued after the last window to flush the datapath

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst, in, 1, synchronous active-high reset
- start, in, 1, one-cycle pulse that begins a layer
- src_valid, in, 1, current 3x3 window and weights are present at the datapath inputs
- dp_done, in, 1, datapath result strobe
- out_ready, in, 1, downstream accepts the result
- fire, out, 1, datapath advance enable
- busy, out, 1, layer in progress
- layer_done, out, 1, one-cycle pulse at end of layer
- out_valid, out, 1, result pending downstream
- row, out, ADDR_BITS, current output row
- col, out, ADDR_BITS, current output column
- ch_grp, out, 8, current channel group
- wt_addr, out, 8, weight memory address
- ovf_err, out, 1, sticky result-overrun flag

REQ-003 The block SHALL use one clock with a synchronous, active-high reset (rst); all flops SHALL update only on the rising edge of clk.

Function
REQ-004 The FSM SHALL have four states with these transitions:
- IDLE -> RUN on start
- RUN -> DRAIN after the last window is fired
- DRAIN -> DONE after DRAIN_CYCLES fires
- DONE -> IDLE unconditionally after one cycle

REQ-005 The block SHALL assert busy in RUN, DRAIN and DONE, and SHALL deassert it in IDLE.

REQ-006 The block SHALL define stall = out_valid & ~out_ready.

REQ-007 fire SHALL be combinational and SHALL be asserted:
- in RUN, when src_valid & ~stall
- in DRAIN, when ~stall
- in no other state

REQ-008 The counters SHALL use this loop order, col innermost, then ch_grp, then row, and each SHALL advance only on fire in RUN:
- col increments, wrapping INPUT_SIZE-1 -> 0
- on col wrap, ch_grp increments, wrapping ITER-1 -> 0
- on ch_grp wrap, row increments

REQ-009 The fire with row=col=INPUT_SIZE-1 and ch_grp=ITER-1 SHALL be the last RUN fire; the block SHALL enter DRAIN next cycle with row, col and ch_grp held at 0.

REQ-010 wt_addr SHALL equal ch_grp, registered in the same cycle.

REQ-011 A layer SHALL issue exactly INPUT_SIZE*INPUT_SIZE*ITER RUN fires followed by DRAIN_CYCLES DRAIN fires.

REQ-012 The DRAIN counter SHALL count fires, not cycles, so stalled cycles SHALL NOT count.

REQ-013 layer_done SHALL be high for exactly the one cycle spent in DONE.

REQ-014 out_valid SHALL be set the cycle after dp_done, cleared the cycle after out_valid & out_ready, and remain set if dp_done and a handshake coincide.

REQ-015 If dp_done arrives while stall is true, ovf_err SHALL set and remain set until rst.

REQ-016 start while busy SHALL be ignored.

REQ-017 src_valid low in RUN SHALL hold all counters and the FSM state.

REQ-018 The block SHALL perform no arithmetic beyond the counters; counter comparisons SHALL be unsigned.

Reset
REQ-019 On rst, next edge, the block SHALL set:
- state IDLE
- row, col, ch_grp, wt_addr and the drain counter to 0
- out_valid, layer_done and ovf_err to 0

REQ-020 During rst, fire and busy SHALL be 0.

REQ-021 rst mid-layer SHALL abort the layer without a layer_done pulse; a later start SHALL begin from row=col=ch_grp=0.

REQ-022 rst SHALL have priority over start, dp_done and out_ready in the same cycle.

Verification
REQ-023 The bench SHALL cover these directed scenarios (INPUT_SIZE=4, TI=3, INPUT_CHANNEL=6):
- Nominal: src_valid=1, out_ready=1, start pulse -> 32 RUN fires + 5 DRAIN fires = 37 fires; one layer_done pulse 39 cycles after start; ovf_err=0.
- Loop order: same run -> col 0..3 repeats; ch_grp toggles 0/1 at each col wrap; row increments after ch_grp=1,col=3; wt_addr tracks ch_grp.
- Source gaps: src_valid low every other cycle -> still exactly 37 fires; counters frozen while src_valid=0; layer_done delayed accordingly.
- Backpressure: dp_done with out_ready=0 -> out_valid=1, fire=0 until out_ready=1; a second dp_done during the stall -> ovf_err=1 and sticky.
- Reset and restart: rst asserted at fire #10, start issued during busy -> no layer_done; state IDLE; start ignored; a fresh start gives the nominal 37 fires.
